// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the memory.
// The slave modport is the arbiter's view; master is the environment's view
// (fetch unit, load/store unit and memory together).
interface mem_arbiter_if;

    logic [31:0] if_addr;
    logic        if_rstrobe;
    logic [31:0] if_rdata;
    logic        if_done;

    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic        d_wstrobe;
    logic        d_rstrobe;
    logic [31:0] d_rdata;
    logic        d_done;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_wstrobe;
    logic        mem_rstrobe;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_addr, if_rstrobe,
        input  d_addr, d_wdata, d_wmask, d_wstrobe, d_rstrobe,
        input  mem_rdata,
        output if_rdata, if_done, d_rdata, d_done,
        output mem_addr, mem_wdata, mem_wmask, mem_wstrobe, mem_rstrobe
    );

    modport master (
        output if_addr, if_rstrobe,
        output d_addr, d_wdata, d_wmask, d_wstrobe, d_rstrobe,
        output mem_rdata,
        input  if_rdata, if_done, d_rdata, d_done,
        input  mem_addr, mem_wdata, mem_wmask, mem_wstrobe, mem_rstrobe
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory arbiter.
// Default: round-robin against the last granted port.
// With MEM_ARB_DATA_PRIO_EN defined: data port has priority, but fetch wins
// a tie once MAX_CONSEC consecutive data grants have starved it.
module mem_arb_pick
    import mem_arb_pkg::*;
`ifdef MEM_ARB_DATA_PRIO_EN
#(
    parameter int unsigned MAX_CONSEC = 4
)
`endif
(
    input  logic       if_req_i,
    input  logic       d_req_i,
`ifdef MEM_ARB_DATA_PRIO_EN
    input  logic [3:0] cnt_i,
`else
    input  logic       last_i,
`endif
    output logic       win_vld_o,
    output logic       winner_o
);

    // A single requester always wins; ties go to the arbitration policy.
    always_comb begin
        win_vld_o = if_req_i | d_req_i;
        winner_o  = PORT_IF;
        if (if_req_i && d_req_i) begin
`ifdef MEM_ARB_DATA_PRIO_EN
            winner_o = (cnt_i == 4'(MAX_CONSEC)) ? PORT_IF : PORT_D;
`else
            winner_o = ~last_i;
`endif
        end else if (d_req_i) begin
            winner_o = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port synchronous memory between
// instruction fetch (read-only) and the data port (read/write).
// Each access is one issue cycle (IDLE) followed by one response cycle (RESP).
// Optional feature macro: MEM_ARB_DATA_PRIO_EN (data-port priority with a
// starvation limit of MAX_CONSEC consecutive data grants).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_CONSEC = 4
)
(
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    arb_state_t state_q;
    logic       grant_q;
    logic       last_q;
    logic       if_done_q;
    logic       d_done_q;

    logic       if_req;
    logic       d_req;
    logic       win_vld;
    logic       winner;
    logic       issue;
    logic       sel;

    assign if_req = bus.if_rstrobe;
    assign d_req  = bus.d_rstrobe | bus.d_wstrobe;

`ifdef MEM_ARB_DATA_PRIO_EN
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       unused_last;

    // last is kept for visibility only; priority mode decides ties on cnt.
    assign unused_last = last_q;

    mem_arb_pick #(
        .MAX_CONSEC (MAX_CONSEC)
    ) u_pick (
        .if_req_i  (if_req),
        .d_req_i   (d_req),
        .cnt_i     (cnt_q),
        .win_vld_o (win_vld),
        .winner_o  (winner)
    );

    // Count data grants that kept a waiting fetch out; any other grant clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (issue) begin
            if ((winner == PORT_D) && if_req) begin
                cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
            end else begin
                cnt_d = '0;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_max_consec;

    // MAX_CONSEC only affects the data-priority build.
    assign unused_max_consec = (MAX_CONSEC == 0);

    mem_arb_pick u_pick (
        .if_req_i  (if_req),
        .d_req_i   (d_req),
        .last_i    (last_q),
        .win_vld_o (win_vld),
        .winner_o  (winner)
    );
`endif

    assign issue = (state_q == ARB_IDLE) && win_vld;

    // During an issue the fresh winner owns the bus; otherwise the granted port's
    // address/data stay on it (needed through RESP, harmless while idle).
    assign sel = issue ? winner : grant_q;

    // Memory-side drive; strobes only in the issue cycle and forced low in reset.
    always_comb begin
        bus.mem_addr    = (sel == PORT_D) ? bus.d_addr  : bus.if_addr;
        bus.mem_wdata   = (sel == PORT_D) ? bus.d_wdata : '0;
        bus.mem_wmask   = (sel == PORT_D) ? bus.d_wmask : '0;
        bus.mem_rstrobe = 1'b0;
        bus.mem_wstrobe = 1'b0;
        if (issue && rst_n) begin
            if (winner == PORT_D) begin
                bus.mem_rstrobe = bus.d_rstrobe;
                bus.mem_wstrobe = bus.d_wstrobe;
            end else begin
                bus.mem_rstrobe = bus.if_rstrobe;
            end
        end
    end

    // Issue/response sequencer: every grant is followed by exactly one RESP cycle
    // in which the granted port sees its done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            grant_q   <= PORT_IF;
            last_q    <= PORT_D;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if_done_q <= 1'b0;
                    d_done_q  <= 1'b0;
                    if (win_vld) begin
                        state_q   <= ARB_RESP;
                        grant_q   <= winner;
                        last_q    <= winner;
                        if_done_q <= (winner == PORT_IF);
                        d_done_q  <= (winner == PORT_D);
                    end
                end
                ARB_RESP: begin
                    state_q   <= ARB_IDLE;
                    if_done_q <= 1'b0;
                    d_done_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ARB_IDLE;
                    if_done_q <= 1'b0;
                    d_done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Read data is passed straight through; done qualifies it.
    assign bus.if_done  = if_done_q;
    assign bus.d_done   = d_done_q;
    assign bus.if_rdata = bus.mem_rdata;
    assign bus.d_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level reference model.
// Build with MEM_ARB_DATA_PRIO_EN defined to exercise the data-priority variant.
module tb_mem_arbiter;

    localparam int unsigned MAX_CONSEC = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .MAX_CONSEC (MAX_CONSEC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Synchronous word memory: registered read of the pre-write word, byte-masked write.
    logic [31:0] mem [0:63];
    logic        ld_en;
    logic [5:0]  ld_idx;
    logic [31:0] ld_val;

    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_val;
        if (bus.mem_rstrobe) bus.mem_rdata <= mem[bus.mem_addr[7:2]];
        if (bus.mem_wstrobe) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wmask[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end

    // Reference arbitration state.
`ifdef MEM_ARB_DATA_PRIO_EN
    int m_cnt;
`else
    logic m_last;
`endif
    logic [31:0] shadow [0:15];

    function automatic logic m_pick(input logic fi, input logic di);
        if (fi && !di) return 1'b0;
        if (di && !fi) return 1'b1;
`ifdef MEM_ARB_DATA_PRIO_EN
        return (m_cnt == MAX_CONSEC) ? 1'b0 : 1'b1;
`else
        return ~m_last;
`endif
    endfunction

    task automatic m_grant(input logic w, input logic fi);
`ifdef MEM_ARB_DATA_PRIO_EN
        if (w && fi) m_cnt++;
        else m_cnt = 0;
`else
        if (fi || !fi) m_last = w;
`endif
    endtask

    task automatic m_reset();
`ifdef MEM_ARB_DATA_PRIO_EN
        m_cnt = 0;
`else
        m_last = 1'b1;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic load(input int idx, input logic [31:0] v);
        ld_en  = 1'b1;
        ld_idx = idx[5:0];
        ld_val = v;
        step();
        ld_en  = 1'b0;
    endtask

    task automatic drop_all();
        bus.if_rstrobe = 1'b0;
        bus.d_rstrobe  = 1'b0;
        bus.d_wstrobe  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_reset();
    endtask

    logic [9:0]  cont_seq;
    logic        w;
    logic        g;
    logic        if_pend;
    logic        d_pend;
    logic        m_resp;
    logic        exp_rd_vld;
    logic [31:0] exp_rd;
    logic [3:0]  wi;
    logic [3:0]  wd;

    initial begin
`ifdef MEM_ARB_DATA_PRIO_EN
        cont_seq = 10'b0111101111;   // bit i = port of grant i (1 = data): D D D D F D D D D F
`else
        cont_seq = 10'b1010101010;   // F D F D F D F D F D
`endif
        rst_n = 1'b0;
        ld_en = 1'b0; ld_idx = '0; ld_val = '0;
        bus.if_addr = '0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wmask = '0;
        bus.if_rstrobe = 1'b1; bus.d_wstrobe = 1'b1; bus.d_rstrobe = 1'b0;
        m_reset();
        step();
        step();

        // Reset: requests present but everything quiet.
        chk1("rst_if_done", bus.if_done, 1'b0);
        chk1("rst_d_done", bus.d_done, 1'b0);
        chk1("rst_mem_rs", bus.mem_rstrobe, 1'b0);
        chk1("rst_mem_ws", bus.mem_wstrobe, 1'b0);
        drop_all();
        load(3, 32'h0000_0013);
        load(2, 32'h0000_0000);
        load(5, 32'h1111_1111);
        rst_n = 1'b1;
        step();

        // Single fetch.
        bus.if_addr = 32'hC; bus.if_rstrobe = 1'b1;
        #1;
        chk1("fetch_issue_rs", bus.mem_rstrobe, 1'b1);
        chk1("fetch_issue_ws", bus.mem_wstrobe, 1'b0);
        chk("fetch_issue_addr", bus.mem_addr, 32'hC);
        chk1("fetch_issue_done", bus.if_done, 1'b0);
        step();
        chk1("fetch_done", bus.if_done, 1'b1);
        chk("fetch_rdata", bus.if_rdata, 32'h0000_0013);
        chk1("fetch_d_done", bus.d_done, 1'b0);
        chk1("fetch_resp_rs", bus.mem_rstrobe, 1'b0);
        chk("fetch_resp_addr", bus.mem_addr, 32'hC);
        drop_all();
        step();
        chk1("fetch_after_done", bus.if_done, 1'b0);

        // Byte write then read.
        bus.d_addr = 32'h8; bus.d_wdata = 32'hAABB_CCDD; bus.d_wmask = 4'b0010; bus.d_wstrobe = 1'b1;
        #1;
        chk1("wr_issue_ws", bus.mem_wstrobe, 1'b1);
        chk1("wr_issue_rs", bus.mem_rstrobe, 1'b0);
        chk("wr_issue_mask", 32'(bus.mem_wmask), 32'h2);
        step();
        chk1("wr_d_done", bus.d_done, 1'b1);
        chk1("wr_if_done", bus.if_done, 1'b0);
        drop_all();
        step();
        bus.d_rstrobe = 1'b1;
        #1;
        chk1("rd_issue_rs", bus.mem_rstrobe, 1'b1);
        step();
        chk1("rd_d_done", bus.d_done, 1'b1);
        chk("rd_byte_rdata", bus.d_rdata, 32'h0000_CC00);
        drop_all();
        step();

        // Read-before-write.
        bus.d_addr = 32'h14; bus.d_wdata = 32'h2222_2222; bus.d_wmask = 4'hF;
        bus.d_rstrobe = 1'b1; bus.d_wstrobe = 1'b1;
        #1;
        chk1("rbw_issue_ws", bus.mem_wstrobe, 1'b1);
        chk1("rbw_issue_rs", bus.mem_rstrobe, 1'b1);
        step();
        chk1("rbw_done", bus.d_done, 1'b1);
        chk("rbw_old_rdata", bus.d_rdata, 32'h1111_1111);
        drop_all();
        step();
        bus.d_rstrobe = 1'b1;
        step();
        chk1("rbw_rd_done", bus.d_done, 1'b1);
        chk("rbw_new_rdata", bus.d_rdata, 32'h2222_2222);
        drop_all();
        step();

        // Contention after reset, both held.
        do_reset();
        bus.if_addr = 32'hC; bus.if_rstrobe = 1'b1;
        bus.d_addr = 32'h14; bus.d_rstrobe = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 1) begin
                g = cont_seq[i/2];
                chk1($sformatf("cont_if_done_c%0d", i), bus.if_done, ~g);
                chk1($sformatf("cont_d_done_c%0d", i), bus.d_done, g);
                chk($sformatf("cont_rdata_c%0d", i), bus.mem_rdata, g ? 32'h2222_2222 : 32'h0000_0013);
            end else begin
                chk1($sformatf("cont_if_idle_c%0d", i), bus.if_done, 1'b0);
                chk1($sformatf("cont_d_idle_c%0d", i), bus.d_done, 1'b0);
            end
            step();
        end
        drop_all();
        step();

        // Reset asserted during RESP.
        do_reset();
        bus.if_rstrobe = 1'b1; bus.d_rstrobe = 1'b1;
        #1;
        w = m_pick(1'b1, 1'b1);
        step();
        chk1("midrst_pre_done", w ? bus.d_done : bus.if_done, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("midrst_if_done", bus.if_done, 1'b0);
        chk1("midrst_d_done", bus.d_done, 1'b0);
        chk1("midrst_mem_rs", bus.mem_rstrobe, 1'b0);
        chk1("midrst_mem_ws", bus.mem_wstrobe, 1'b0);
        step();
        rst_n = 1'b1;
        m_reset();
        #1;
        w = m_pick(1'b1, 1'b1);
        chk1("postrst_issue_rs", bus.mem_rstrobe, 1'b1);
        chk("postrst_issue_addr", bus.mem_addr, w ? 32'h14 : 32'hC);
        step();
        chk1("postrst_if_done", bus.if_done, ~w);
        chk1("postrst_d_done", bus.d_done, w);
        drop_all();
        step();

        // Randomized traffic against the transaction-level model.
        do_reset();
        drop_all();
        for (int k = 0; k < 16; k++) begin
            shadow[k] = $urandom;
            load(k, shadow[k]);
        end
        if_pend = 1'b0; d_pend = 1'b0; m_resp = 1'b0;
        exp_rd_vld = 1'b0; exp_rd = '0; w = 1'b0;
        wi = '0; wd = '0;
        for (int it = 0; it < 600; it++) begin
            if (!m_resp) begin
                if (!if_pend && ($urandom_range(0, 1) == 1)) begin
                    if_pend = 1'b1;
                    wi = 4'($urandom_range(0, 15));
                    bus.if_addr = {26'b0, wi, 2'b00};
                    bus.if_rstrobe = 1'b1;
                end
                if (!d_pend && ($urandom_range(0, 1) == 1)) begin
                    d_pend = 1'b1;
                    wd = 4'($urandom_range(0, 15));
                    bus.d_addr = {26'b0, wd, 2'b00};
                    bus.d_wdata = $urandom;
                    bus.d_wmask = 4'($urandom_range(0, 15));
                    case ($urandom_range(0, 2))
                        0: begin bus.d_rstrobe = 1'b1; bus.d_wstrobe = 1'b0; end
                        1: begin bus.d_rstrobe = 1'b0; bus.d_wstrobe = 1'b1; end
                        default: begin bus.d_rstrobe = 1'b1; bus.d_wstrobe = 1'b1; end
                    endcase
                end
                #1;
                chk1("rnd_idle_if_done", bus.if_done, 1'b0);
                chk1("rnd_idle_d_done", bus.d_done, 1'b0);
                if (if_pend || d_pend) begin
                    w = m_pick(if_pend, d_pend);
                    if (w) begin
                        chk1("rnd_d_rs", bus.mem_rstrobe, bus.d_rstrobe);
                        chk1("rnd_d_ws", bus.mem_wstrobe, bus.d_wstrobe);
                        chk("rnd_d_addr", bus.mem_addr, {26'b0, wd, 2'b00});
                        exp_rd_vld = bus.d_rstrobe;
                        exp_rd = shadow[wd];
                        if (bus.d_wstrobe) begin
                            chk("rnd_d_wmask", 32'(bus.mem_wmask), 32'(bus.d_wmask));
                            for (int b = 0; b < 4; b++) begin
                                if (bus.d_wmask[b]) shadow[wd][8*b +: 8] = bus.d_wdata[8*b +: 8];
                            end
                        end
                    end else begin
                        chk1("rnd_f_rs", bus.mem_rstrobe, 1'b1);
                        chk1("rnd_f_ws", bus.mem_wstrobe, 1'b0);
                        chk("rnd_f_addr", bus.mem_addr, {26'b0, wi, 2'b00});
                        exp_rd_vld = 1'b1;
                        exp_rd = shadow[wi];
                    end
                    m_grant(w, if_pend);
                    m_resp = 1'b1;
                end else begin
                    chk1("rnd_quiet_rs", bus.mem_rstrobe, 1'b0);
                    chk1("rnd_quiet_ws", bus.mem_wstrobe, 1'b0);
                end
            end else begin
                chk1("rnd_resp_if_done", bus.if_done, ~w);
                chk1("rnd_resp_d_done", bus.d_done, w);
                chk1("rnd_resp_rs", bus.mem_rstrobe, 1'b0);
                chk1("rnd_resp_ws", bus.mem_wstrobe, 1'b0);
                if (exp_rd_vld) chk("rnd_resp_rdata", w ? bus.d_rdata : bus.if_rdata, exp_rd);
                if (w) begin
                    bus.d_rstrobe = 1'b0; bus.d_wstrobe = 1'b0; d_pend = 1'b0;
                end else begin
                    bus.if_rstrobe = 1'b0; if_pend = 1'b0;
                end
                m_resp = 1'b0;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
